// File: rtl/display_ctrl.sv
// Four-digit BCD display register bank shared by the balance and message paths.
// Round-robin grant, sequential double-dabble conversion, leading-zero blanking, saturation and blink.
module display_ctrl #(
  parameter int WIDTH        = 14,
  parameter int BLINK_CYCLES = 500
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bal_req,
  input  logic [WIDTH-1:0] bal_val,
  output logic             bal_ack,
  input  logic             msg_req,
  input  logic [WIDTH-1:0] msg_val,
  output logic             msg_ack,
  input  logic             blank_lz,
  input  logic             blink_en,
  output logic [3:0]       D3,
  output logic [3:0]       D2,
  output logic [3:0]       D1,
  output logic [3:0]       D0,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BC_W  = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t               state, state_nxt;
  logic                 last_msg;
  logic                 grant_bal, grant_msg;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     bin;
  logic [15:0]          bcd;
  logic                 sat;
  logic [15+WIDTH:0]    shift_nxt;
  logic [3:0]           d3_q, d2_q, d1_q, d0_q;
  logic [BC_W-1:0]      blink_cnt;
  logic                 blink_ph;
  logic                 blank3, blank2, blank1;

  function automatic logic [15:0] dabble(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic over_range(input logic [WIDTH-1:0] v);
    return (v > WIDTH'(9999));
  endfunction

  // Arbitration and next state
  always_comb begin
    state_nxt = state;
    grant_bal = 1'b0;
    grant_msg = 1'b0;
    shift_nxt = {dabble(bcd), bin} << 1;
    case (state)
      IDLE: begin
        // On a tie, the requester that did not win last time gets the display.
        if (bal_req && (!msg_req || last_msg)) grant_bal = 1'b1;
        else if (msg_req)                      grant_msg = 1'b1;
        if (grant_bal || grant_msg) state_nxt = SHIFT;
      end
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and committed display state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      last_msg <= 1'b1;
      cnt      <= '0;
      bal_ack  <= 1'b0;
      msg_ack  <= 1'b0;
      d3_q     <= 4'd0;
      d2_q     <= 4'd0;
      d1_q     <= 4'd0;
      d0_q     <= 4'd0;
      ovf      <= 1'b0;
    end else begin
      state   <= state_nxt;
      bal_ack <= grant_bal;
      msg_ack <= grant_msg;
      if (grant_bal || grant_msg) begin
        last_msg <= grant_msg;
        cnt      <= CNT_W'(WIDTH);
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == COMMIT) begin
        if (sat) begin
          {d3_q, d2_q, d1_q, d0_q} <= 16'h9999;
          ovf <= 1'b1;
        end else begin
          {d3_q, d2_q, d1_q, d0_q} <= bcd;
          ovf <= 1'b0;
        end
      end
    end
  end

  // Conversion scratch registers
  always_ff @(posedge CLK) begin
    if (grant_bal || grant_msg) begin
      bin <= grant_msg ? msg_val : bal_val;
      bcd <= '0;
      sat <= over_range(grant_msg ? msg_val : bal_val);
    end else if (state == SHIFT) begin
      {bcd, bin} <= shift_nxt;
    end
  end

  // Blink timebase
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BC_W'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BC_W'(1);
    end
  end

  assign busy   = (state != IDLE);
  assign blank3 = blank_lz && (d3_q == 4'd0);
  assign blank2 = blank3 && (d2_q == 4'd0);
  assign blank1 = blank2 && (d1_q == 4'd0);

  assign D3 = (blink_ph || blank3) ? 4'hF : d3_q;
  assign D2 = (blink_ph || blank2) ? 4'hF : d2_q;
  assign D1 = (blink_ph || blank1) ? 4'hF : d1_q;
  assign D0 = blink_ph ? 4'hF : d0_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed testbench for display_ctrl: arbitration, conversion, blanking, saturation, blink, reset.
module tb_display_ctrl;

  logic        CLK;
  logic        RST;
  logic        bal_req, msg_req;
  logic [13:0] bal_val, msg_val;
  logic        bal_ack, msg_ack;
  logic        blank_lz, blink_en;
  logic [3:0]  D3, D2, D1, D0;
  logic        busy, ovf;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  display_ctrl #(.WIDTH(14), .BLINK_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .bal_req(bal_req), .bal_val(bal_val), .bal_ack(bal_ack),
    .msg_req(msg_req), .msg_val(msg_val), .msg_ack(msg_ack),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .D3(D3), .D2(D2), .D1(D1), .D0(D0),
    .busy(busy), .ovf(ovf)
  );

  assign disp = {D3, D2, D1, D0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issue one request, drop it after the grant edge, and follow it to the commit edge.
  task automatic run_req(input bit is_msg, input logic [13:0] val,
                         output bit ack_first, output int ack_cnt, output int busy_cnt);
    @(negedge CLK);
    if (is_msg) begin msg_req = 1'b1; msg_val = val; end
    else        begin bal_req = 1'b1; bal_val = val; end
    @(posedge CLK); #1;
    bal_req = 1'b0; msg_req = 1'b0;
    ack_first = is_msg ? msg_ack : bal_ack;
    ack_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bal_ack || msg_ack) ack_cnt++;
      if (!busy) break;
      busy_cnt++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; blank_lz = 1'b1; #2;
    checks++; if (disp !== 16'hFFF0) begin errors++; $display("FAIL reset_blank_lz: got %h want fff0", disp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if ({bal_ack, msg_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {bal_ack, msg_ack}); end
    blank_lz = 1'b0; #1;
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_no_blank: got %h want 0000", disp); end
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_basic();
    bit a1; int ac, bc;
    blank_lz = 1'b0;
    run_req(1'b0, 14'd1234, a1, ac, bc);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL basic_ack_timing: got %b want 1", a1); end
    checks++; if (ac != 1) begin errors++; $display("FAIL basic_ack_pulses: got %0d want 1", ac); end
    checks++; if (bc != 15) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 15", bc); end
    checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL basic_digits: got %h want 1234", disp); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_blanking();
    bit a1; int ac, bc;
    blank_lz = 1'b1;
    run_req(1'b0, 14'd7, a1, ac, bc);
    checks++; if (disp !== 16'hFFF7) begin errors++; $display("FAIL blank_7: got %h want fff7", disp); end
    blank_lz = 1'b0; #1;
    checks++; if (disp !== 16'h0007) begin errors++; $display("FAIL noblank_7: got %h want 0007", disp); end
    blank_lz = 1'b1;
    run_req(1'b0, 14'd0, a1, ac, bc);
    checks++; if (disp !== 16'hFFF0) begin errors++; $display("FAIL blank_0: got %h want fff0", disp); end
    run_req(1'b0, 14'd1004, a1, ac, bc);
    checks++; if (disp !== 16'h1004) begin errors++; $display("FAIL blank_1004: got %h want 1004", disp); end
    run_req(1'b0, 14'd60, a1, ac, bc);
    checks++; if (disp !== 16'hFF60) begin errors++; $display("FAIL blank_60: got %h want ff60", disp); end
  endtask

  task automatic test_saturation();
    bit a1; int ac, bc;
    blank_lz = 1'b0;
    run_req(1'b1, 14'd12000, a1, ac, bc);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL sat_msg_ack: got %b want 1", a1); end
    checks++; if (disp !== 16'h9999) begin errors++; $display("FAIL sat_12000: got %h want 9999", disp); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_12000_ovf: got %b want 1", ovf); end
    run_req(1'b1, 14'd9999, a1, ac, bc);
    checks++; if (disp !== 16'h9999 || ovf !== 1'b0) begin errors++; $display("FAIL sat_9999: got %h ovf %b want 9999 ovf 0", disp, ovf); end
    run_req(1'b1, 14'd10000, a1, ac, bc);
    checks++; if (disp !== 16'h9999 || ovf !== 1'b1) begin errors++; $display("FAIL sat_10000: got %h ovf %b want 9999 ovf 1", disp, ovf); end
    blank_lz = 1'b1;
    run_req(1'b0, 14'd50, a1, ac, bc);
    checks++; if (disp !== 16'hFF50) begin errors++; $display("FAIL sat_then_50: got %h want ff50", disp); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_then_50_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_arbitration();
    int ev_who[3];
    int ev_cyc[3];
    int n_ev;
    bit both;
    for (int i = 0; i < 3; i++) begin ev_who[i] = -1; ev_cyc[i] = -1; end
    n_ev = 0; both = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    blank_lz = 1'b0;
    bal_val = 14'd111; msg_val = 14'd222;
    bal_req = 1'b1; msg_req = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(posedge CLK); #1;
      if (bal_ack && msg_ack) both = 1'b1;
      if ((bal_ack || msg_ack) && n_ev < 3) begin
        ev_who[n_ev] = msg_ack ? 1 : 0;
        ev_cyc[n_ev] = i;
      end
      if (bal_ack || msg_ack) n_ev++;
    end
    bal_req = 1'b0; msg_req = 1'b0;
    checks++; if (n_ev != 3) begin errors++; $display("FAIL arb_grant_count: got %0d want 3", n_ev); end
    checks++; if (both) begin errors++; $display("FAIL arb_double_ack: got both acks together want one"); end
    checks++; if (ev_who[0] != 0 || ev_cyc[0] != 0) begin errors++; $display("FAIL arb_first: got who %0d cyc %0d want 0 0", ev_who[0], ev_cyc[0]); end
    checks++; if (ev_who[1] != 1 || ev_cyc[1] != 16) begin errors++; $display("FAIL arb_second: got who %0d cyc %0d want 1 16", ev_who[1], ev_cyc[1]); end
    checks++; if (ev_who[2] != 0 || ev_cyc[2] != 32) begin errors++; $display("FAIL arb_third: got who %0d cyc %0d want 0 32", ev_who[2], ev_cyc[2]); end
    checks++; if (disp !== 16'h0111) begin errors++; $display("FAIL arb_last_value: got %h want 0111", disp); end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_blink();
    bit a1; int ac, bc;
    logic [15:0] exp;
    blank_lz = 1'b0;
    run_req(1'b0, 14'd1234, a1, ac, bc);
    blink_en = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge CLK); #1;
      exp = (((e / 4) % 2) == 0) ? 16'h1234 : 16'hFFFF;
      checks++; if (disp !== exp) begin errors++; $display("FAIL blink_edge%0d: got %h want %h", e, disp, exp); end
    end
    blink_en = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge CLK); #1;
      checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL blink_off%0d: got %h want 1234", e, disp); end
    end
  endtask

  task automatic test_reset_midconv();
    bit a1; int ac, bc;
    blank_lz = 1'b1;
    run_req(1'b1, 14'd12000, a1, ac, bc);
    @(negedge CLK);
    bal_req = 1'b1; bal_val = 14'd9876;
    @(posedge CLK); #1;
    bal_req = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midconv_busy_before: got %b want 1", busy); end
    RST = 1'b1; #1;
    checks++; if (disp !== 16'hFFF0) begin errors++; $display("FAIL midconv_reset_digits: got %h want fff0", disp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midconv_reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midconv_reset_ovf: got %b want 0", ovf); end
    @(negedge CLK); RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    checks++; if (disp !== 16'hFFF0) begin errors++; $display("FAIL midconv_no_commit: got %h want fff0", disp); end
    checks++; if (busy !== 1'b0 || {bal_ack, msg_ack} !== 2'b00) begin errors++; $display("FAIL midconv_idle: got busy %b acks %b want 0 00", busy, {bal_ack, msg_ack}); end
  endtask

  initial begin
    bal_req = 1'b0; msg_req = 1'b0;
    bal_val = '0;   msg_val = '0;
    blank_lz = 1'b1; blink_en = 1'b0;
    RST = 1'b1;
    test_reset();
    test_basic();
    test_blanking();
    test_saturation();
    test_arbitration();
    test_blink();
    test_reset_midconv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
